// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: FSM state type, nibble width and counter-width helper
// shared by the nibble-serial adder. No ports.
package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int NIB_W = 4;

  function automatic int cnt_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: 4-bit combinational adder.
// Ports: a, b (4b), cin -> sum (4b), cout.
module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add, one nibble per cycle through a 4-bit adder.
// Ports: clk, rst_n, in_valid/in_ready/a/b/cin, out_valid/out_ready/sum/cout[/ovf with NIBBLE_SERIAL_ADDER_OVF_EN].
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int CW  = cnt_w(NIB);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [NIB_W-1:0] an;
  logic [NIB_W-1:0] bn;
  logic [NIB_W-1:0] sn;
  logic             cn;
  logic             last;

  assign an   = a_q[int'(cnt_q)*NIB_W +: NIB_W];
  assign bn   = b_q[int'(cnt_q)*NIB_W +: NIB_W];
  assign last = (cnt_q == CW'(NIB - 1));

  ripple_carry_adder u_rca (
    .a    (an),
    .b    (bn),
    .cin  (carry_q),
    .sum  (sn),
    .cout (cn)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 throughout reset.
  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_q[int'(cnt_q)*NIB_W +: NIB_W] <= sn;
          carry_q <= cn;
          cnt_q   <= cnt_q + CW'(1);
          if (last) cout_q <= cn;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Carry into the MSB is recovered from the MSB sum bit and its inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last) begin
      ovf_q <= (an[NIB_W-1] ^ bn[NIB_W-1] ^ sn[NIB_W-1]) ^ cn;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed bench with an arithmetic scoreboard
// for a 16-bit and a 4-bit instance of nibble_serial_adder.
module tb_nibble_serial_adder;

  localparam int NIB16 = 4;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        cin16 = 1'b0;
  logic        out_valid16;
  logic        out_ready16 = 1'b1;
  logic [15:0] sum16;
  logic        cout16;

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        cin4 = 1'b0;
  logic        out_valid4;
  logic        out_ready4 = 1'b1;
  logic [3:0]  sum4;
  logic        cout4;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        ovf16;
  logic        ovf4;
`endif

  int checks = 0;
  int errors = 0;

  exp_t q16[$];
  exp_t q4[$];
  int   cyc16 = 0;
  int   cyc4 = 0;
  logic pv16 = 1'b0;
  logic phs16 = 1'b0;
  logic pv4 = 1'b0;
  int   last4 = -1;
  logic sweep4 = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) u16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .sum       (sum16),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .cout      (cout16),
    .ovf       (ovf16)
`else
    .cout      (cout16)
`endif
  );

  nibble_serial_adder #(.WIDTH(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .cout      (cout4),
    .ovf       (ovf4)
`else
    .cout      (cout4)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned sum and signed range test.
  function automatic exp_t mdl(input int w, input logic [15:0] x,
                               input logic [15:0] y, input logic ci);
    exp_t   e;
    longint m;
    longint s;
    longint sx;
    longint sy;
    longint r;
    m  = longint'(1) << w;
    s  = longint'(x) + longint'(y) + longint'(ci);
    sx = x[w-1] ? longint'(x) - m : longint'(x);
    sy = y[w-1] ? longint'(y) - m : longint'(y);
    r  = sx + sy + longint'(ci);
    e.s = 16'(s % m);
    e.c = (s >= m);
    e.o = (r >= m / 2) || (r < -(m / 2));
    e.t = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc16 <= cyc16 + 1;
    if (!rst_n) begin
      q16.delete();
      chk("rst_in_ready16", 32'(in_ready16), 0);
      pv16  <= 1'b0;
      phs16 <= 1'b0;
    end else begin
      if (phs16) begin
        chk("valid_drop16", 32'(out_valid16), 0);
        chk("ready_back16", 32'(in_ready16), 1);
      end
      if (out_valid16) begin
        if (q16.size() == 0) begin
          chk("spurious_valid16", 32'(out_valid16), 0);
        end else begin
          e = q16[0];
          chk("m16_sum", 32'(sum16), 32'(e.s));
          chk("m16_cout", 32'(cout16), 32'(e.c));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          chk("m16_ovf", 32'(ovf16), 32'(e.o));
`endif
          if (!pv16) chk("m16_latency", 32'(cyc16 - e.t), NIB16 + 1);
          if (out_ready16) void'(q16.pop_front());
        end
      end
      if (in_valid16 && in_ready16) begin
        e = mdl(16, a16, b16, cin16);
        e.t = cyc16;
        q16.push_back(e);
      end
      pv16  <= out_valid16;
      phs16 <= out_valid16 && out_ready16;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cyc4 <= cyc4 + 1;
    if (!rst_n) begin
      q4.delete();
      pv4   <= 1'b0;
      last4 <= -1;
    end else begin
      if (out_valid4) begin
        if (q4.size() == 0) begin
          chk("spurious_valid4", 32'(out_valid4), 0);
        end else begin
          e = q4[0];
          chk("m4_sum", 32'(sum4), 32'(e.s));
          chk("m4_cout", 32'(cout4), 32'(e.c));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          chk("m4_ovf", 32'(ovf4), 32'(e.o));
`endif
          if (!pv4) chk("m4_latency", 32'(cyc4 - e.t), 2);
          if (out_ready4) void'(q4.pop_front());
        end
      end
      if (in_valid4 && in_ready4) begin
        if (sweep4 && last4 >= 0) chk("m4_rate", 32'(cyc4 - last4), 3);
        last4 <= cyc4;
        e = mdl(4, {12'h000, a4}, {12'h000, b4}, cin4);
        e.t = cyc4;
        q4.push_back(e);
      end
      pv4 <= out_valid4;
    end
  end

  task automatic op16(input logic [15:0] ai, input logic [15:0] bi,
                      input logic ci, input logic [15:0] es,
                      input logic ec, input logic eo, input int hold);
    logic got;
    @(posedge clk); #1;
    a16 = ai;
    b16 = bi;
    cin16 = ci;
    in_valid16 = 1'b1;
    out_ready16 = (hold == 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = in_ready16;
    end
    chk("accept_timeout", 32'(got), 1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = out_valid16;
    end
    chk("result_timeout", 32'(got), 1);
    chk("lit_sum", 32'(sum16), 32'(es));
    chk("lit_cout", 32'(cout16), 32'(ec));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk("lit_ovf", 32'(ovf16), 32'(eo));
`else
    if (eo === 1'bx) $display("unused ovf expectation");
`endif
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid16), 1);
      chk("hold_in_ready", 32'(in_ready16), 0);
      chk("hold_sum", 32'(sum16), 32'(es));
      chk("hold_cout", 32'(cout16), 32'(ec));
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      out_ready16 = 1'b1;
      @(negedge clk);
      chk("hs_valid", 32'(out_valid16), 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid16), 0);
    chk("rst_sum", 32'(sum16), 0);
    chk("rst_cout", 32'(cout16), 0);
    chk("rst_in_ready", 32'(in_ready16), 0);
    chk("rst_out_valid4", 32'(out_valid4), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_in_ready", 32'(in_ready16), 1);

    op16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    op16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0);
    op16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4);

    @(posedge clk); #1;
    a16 = 16'hAAAA;
    b16 = 16'h5555;
    cin16 = 1'b0;
    in_valid16 = 1'b1;
    out_ready16 = 1'b1;
    @(negedge clk);
    chk("rr_accept", 32'(in_ready16), 1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_out_valid", 32'(out_valid16), 0);
    chk("rr_sum", 32'(sum16), 0);
    chk("rr_cout", 32'(cout16), 0);
    chk("rr_in_ready", 32'(in_ready16), 1);
    repeat (8) begin
      @(negedge clk);
      chk("rr_no_valid", 32'(out_valid16), 0);
    end
    op16(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0);

    op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);

    @(posedge clk); #1;
    sweep4 = 1'b1;
    out_ready4 = 1'b1;
    in_valid4 = 1'b1;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a4 = 4'(ai);
          b4 = 4'(bi);
          cin4 = 1'(ci);
          got = 1'b0;
          for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = in_ready4;
          end
          chk("w4_accept_timeout", 32'(got), 1);
          @(posedge clk); #1;
        end
      end
    end
    in_valid4 = 1'b0;
    for (int i = 0; i < 10 && q4.size() != 0; i++) @(negedge clk);
    chk("w4_drain", 32'(q4.size()), 0);
    for (int i = 0; i < 10 && q16.size() != 0; i++) @(negedge clk);
    chk("w16_drain", 32'(q16.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
